// File: rtl/count16_seq_pkg.sv
// Shared definitions for the count16_seq slice: default widths, the count
// type and its terminal value.
package count_pkg;

   localparam int unsigned WIDTH_DEF    = 16;
   localparam int unsigned PEND_W_DEF   = 8;
   localparam int unsigned PRESCALE_DEF = 4;

   typedef logic [WIDTH_DEF-1:0] cnt_t;

   localparam cnt_t CNT_MAX = '1;

endpackage : count_pkg

// File: rtl/count16_wrap_q.sv
// Pending-wrap event counter: saturating up/down count of undelivered wrap
// events, presented to the consumer through a valid/ready handshake.
`default_nettype none
module count16_wrap_q
   import count_pkg::*;
#(
   parameter int unsigned PEND_W = PEND_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              evt,
   input  logic              rdy,
   output logic              vld,
   output logic [PEND_W-1:0] pend,
   output logic              ovf_set
);

   logic [PEND_W-1:0] r_pend;
   logic              w_acc;
   logic              w_full;

   assign vld    = (r_pend != '0);
   assign w_acc  = vld & rdy;
   assign w_full = (r_pend == '1);

   // A simultaneous event and acceptance cancel out, so saturation is only
   // a loss when nothing is leaving the queue this cycle.
   assign ovf_set = evt & ~w_acc & w_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend <= '0;
      end else if (evt & ~w_acc) begin
         if (!w_full) begin
            r_pend <= r_pend + 1'b1;
         end
      end else if (w_acc & ~evt) begin
         r_pend <= r_pend - 1'b1;
      end
   end

   assign pend = r_pend;

endmodule : count16_wrap_q
`default_nettype wire

// File: rtl/count16_seq.sv
// Count register stage with clr > ld > step priority and wrap-event reporting.
// Optional enable prescaler selected by defining COUNT_PRESCALE_EN.
`default_nettype none
module count16_seq
   import count_pkg::*;
#(
   parameter int unsigned WIDTH    = WIDTH_DEF,
   parameter int unsigned PEND_W   = PEND_W_DEF,
   parameter int unsigned PRESCALE = PRESCALE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              ld,
   input  logic [WIDTH-1:0]  ld_data,
   input  logic              en,
   output logic [WIDTH-1:0]  cnt,
   output logic              tc,
   output logic              wrap_vld,
   input  logic              wrap_rdy,
   output logic [PEND_W-1:0] wrap_pend,
   output logic              ovf
);

   if (PRESCALE < 2) begin : g_prescale_chk
      $error("count16_seq: PRESCALE must be at least 2");
   end

   logic [WIDTH-1:0] r_cnt;
   logic             r_ovf;
   logic             w_tick;
   logic             w_step;
   logic             w_evt;
   logic             w_ovf_set;

`ifdef COUNT_PRESCALE_EN
   localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0] r_ps;
   logic            w_ps_last;

   assign w_ps_last = (r_ps == PS_W'(PRESCALE - 1));
   assign w_tick    = w_ps_last;

   always_ff @(posedge clk) begin
      if (rst || clr || ld) begin
         r_ps <= '0;
      end else if (en) begin
         r_ps <= w_ps_last ? '0 : r_ps + 1'b1;
      end
   end
`else
   assign w_tick = 1'b1;
`endif

   assign w_step = en & ~clr & ~ld & w_tick;
   assign w_evt  = w_step & (r_cnt == '1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (ld) begin
         r_cnt <= ld_data;
      end else if (w_step) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_ovf <= 1'b0;
      end else if (w_ovf_set) begin
         r_ovf <= 1'b1;
      end
   end

   count16_wrap_q #(
      .PEND_W (PEND_W)
   ) u_wrap_q (
      .clk     (clk),
      .rst     (rst),
      .evt     (w_evt),
      .rdy     (wrap_rdy),
      .vld     (wrap_vld),
      .pend    (wrap_pend),
      .ovf_set (w_ovf_set)
   );

   assign cnt = r_cnt;
   assign tc  = (r_cnt == '1);
   assign ovf = r_ovf;

endmodule : count16_seq
`default_nettype wire

// File: tb/tb_count16_seq.sv
// Scoreboard bench for count16_seq: stimulus queues hand-computed state,
// a monitor compares it one edge later.
`timescale 1ns/1ps
module tb_count16_seq;
   import count_pkg::*;

   typedef struct {
      string      nm;
      logic [15:0] cnt;
      logic        tc;
      logic        vld;
      logic [7:0]  pend;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic        ld  = 1'b0;
   logic [15:0] ld_data = '0;
   logic        en  = 1'b0;
   logic        wrap_rdy = 1'b0;
   logic [15:0] cnt;
   logic        tc;
   logic        wrap_vld;
   logic [7:0]  wrap_pend;
   logic        ovf;

   always #5 clk = ~clk;

   count16_seq #(
      .WIDTH    (16),
      .PEND_W   (8),
      .PRESCALE (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .ld        (ld),
      .ld_data   (ld_data),
      .en        (en),
      .cnt       (cnt),
      .tc        (tc),
      .wrap_vld  (wrap_vld),
      .wrap_rdy  (wrap_rdy),
      .wrap_pend (wrap_pend),
      .ovf       (ovf)
   );

   task automatic chk(input string nm, input string fld,
                      input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
      end
   endtask

   // Monitor: the state seen just after each edge answers the stimulus of
   // the preceding cycle, if that cycle queued an expectation.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk(e.nm, "cnt",  32'(cnt),       32'(e.cnt));
         chk(e.nm, "tc",   32'(tc),        32'(e.tc));
         chk(e.nm, "vld",  32'(wrap_vld),  32'(e.vld));
         chk(e.nm, "pend", 32'(wrap_pend), 32'(e.pend));
         chk(e.nm, "ovf",  32'(ovf),       32'(e.ovf));
      end
   end

   // One cycle of stimulus, applied at the falling edge.
   task automatic cyc(input logic r, input logic c, input logic l,
                      input logic [15:0] d, input logic e, input logic rdy,
                      input bit push, input string nm,
                      input logic [15:0] ecnt, input logic etc,
                      input logic evld, input logic [7:0] epend,
                      input logic eovf);
      exp_t x;
      rst = r; clr = c; ld = l; ld_data = d; en = e; wrap_rdy = rdy;
      if (push) begin
         x.nm = nm; x.cnt = ecnt; x.tc = etc; x.vld = evld;
         x.pend = epend; x.ovf = eovf;
         sb.push_back(x);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   initial begin
      cnt_t max_v;
      max_v = CNT_MAX;
      @(negedge clk);
      // Reset dominates en and ld.
      cyc(1, 0, 1, 16'h1234, 1, 0, 1, "rst0", 16'h0000, 0, 0, 8'd0, 0);
      cyc(1, 0, 1, 16'h1234, 1, 0, 1, "rst1", 16'h0000, 0, 0, 8'd0, 0);
`ifdef COUNT_PRESCALE_EN
      cyc(0, 0, 0, 16'h0, 1, 0, 1, "ps1", 16'd0, 0, 0, 8'd0, 0);
      cyc(0, 0, 0, 16'h0, 1, 0, 1, "ps2", 16'd0, 0, 0, 8'd0, 0);
      cyc(0, 0, 0, 16'h0, 1, 0, 1, "ps3", 16'd0, 0, 0, 8'd0, 0);
      cyc(0, 0, 0, 16'h0, 1, 0, 1, "ps4", 16'd1, 0, 0, 8'd0, 0);
      cyc(0, 0, 0, 16'h0, 0, 0, 1, "pshold", 16'd1, 0, 0, 8'd0, 0);
      cyc(0, 0, 0, 16'h0, 1, 0, 1, "ps5", 16'd1, 0, 0, 8'd0, 0);
      cyc(0, 0, 0, 16'h0, 1, 0, 1, "ps6", 16'd1, 0, 0, 8'd0, 0);
      cyc(0, 0, 0, 16'h0, 1, 0, 1, "ps7", 16'd1, 0, 0, 8'd0, 0);
      cyc(0, 0, 0, 16'h0, 1, 0, 1, "ps8", 16'd2, 0, 0, 8'd0, 0);
      // ld zeroes the prescaler: three more en cycles do not step.
      cyc(0, 0, 0, 16'h0, 1, 0, 1, "ps9", 16'd2, 0, 0, 8'd0, 0);
      cyc(0, 0, 1, 16'h0010, 1, 0, 1, "psld", 16'h0010, 0, 0, 8'd0, 0);
      cyc(0, 0, 0, 16'h0, 1, 0, 0, "", 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 16'h0, 1, 0, 0, "", 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 16'h0, 1, 0, 1, "psld3", 16'h0010, 0, 0, 8'd0, 0);
      cyc(0, 0, 0, 16'h0, 1, 0, 1, "psld4", 16'h0011, 0, 0, 8'd0, 0);
`else
      cyc(0, 0, 1, 16'hFFFE, 0, 0, 1, "ldFFFE", 16'hFFFE, 0, 0, 8'd0, 0);
      cyc(0, 0, 0, 16'h0, 1, 0, 1, "stepMax", max_v, 1, 0, 8'd0, 0);
      cyc(0, 0, 0, 16'h0, 1, 0, 1, "wrap1", 16'h0000, 0, 1, 8'd1, 0);
      cyc(0, 0, 0, 16'h0, 0, 1, 1, "drain1", 16'h0000, 0, 0, 8'd0, 0);
      cyc(0, 0, 0, 16'h0, 0, 1, 1, "rdyIdle", 16'h0000, 0, 0, 8'd0, 0);
      // 256 wraps with no consumer: the 256th is lost and sets ovf.
      for (int i = 0; i < 256; i++) begin
         cyc(0, 0, 1, 16'hFFFF, 0, 0, 0, "", 0, 0, 0, 0, 0);
         cyc(0, 0, 0, 16'h0, 1, 0, bit'(i >= 254),
             (i == 255) ? "sat256" : "sat255",
             16'h0000, 0, 1, 8'd255, logic'(i == 255));
      end
      cyc(0, 1, 0, 16'h0, 0, 0, 1, "clrOvf", 16'h0000, 0, 1, 8'd255, 0);
      for (int i = 0; i < 252; i++) begin
         cyc(0, 0, 0, 16'h0, 0, 1, bit'(i == 251), "drainTo3",
             16'h0000, 0, 1, 8'd3, 0);
      end
      cyc(0, 0, 1, 16'hFFFF, 0, 0, 1, "ldMax", 16'hFFFF, 1, 1, 8'd3, 0);
      cyc(0, 0, 0, 16'h0, 1, 1, 1, "evtAcc", 16'h0000, 0, 1, 8'd3, 0);
      cyc(0, 0, 1, 16'h1234, 0, 0, 1, "ld1234", 16'h1234, 0, 1, 8'd3, 0);
      cyc(0, 1, 1, 16'h5555, 1, 0, 1, "clrPrio", 16'h0000, 0, 1, 8'd3, 0);
      cyc(0, 0, 1, 16'h5555, 1, 0, 1, "ldPrio", 16'h5555, 0, 1, 8'd3, 0);
      cyc(0, 0, 0, 16'h0, 1, 0, 1, "step5556", 16'h5556, 0, 1, 8'd3, 0);
      cyc(0, 0, 1, 16'hFFFF, 0, 0, 1, "ldMax2", 16'hFFFF, 1, 1, 8'd3, 0);
      cyc(0, 0, 1, 16'h0000, 1, 0, 1, "ldNoWrap", 16'h0000, 0, 1, 8'd3, 0);
      cyc(0, 0, 1, 16'hFFFF, 0, 0, 1, "ldMax3", 16'hFFFF, 1, 1, 8'd3, 0);
      cyc(1, 0, 0, 16'h0, 1, 1, 1, "rstMid", 16'h0000, 0, 0, 8'd0, 0);
`endif
      cyc(0, 0, 0, 16'h0, 0, 0, 0, "", 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 16'h0, 0, 0, 0, "", 0, 0, 0, 0, 0);
      chk("scoreboard", "left", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_count16_seq
